// File: rtl/mcctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Optional BNE support is enabled elsewhere by the MCCTRL_BNE_EN macro.
package mcctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMMSH  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       trap;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mcctrl_out_decode.sv
// Moore output map: state (plus mem_ready for the memory handshakes) to
// every datapath control. branch_ne is handled in the top level.
module mcctrl_out_decode
  import mcctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ASB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCS_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      DECODE: begin
        // Branch target is precomputed while the opcode is being decoded.
        ctrl_o.alu_src_b = ASB_IMMSH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ASB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCS_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      TRAP:    ctrl_o.trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle fetch/decode/execute sequencer: state register and next-state logic.
// Define MCCTRL_BNE_EN to decode OP_BNE as a branch with branch_ne = 1.
module multicycle_control
  import mcctrl_pkg::*;
#(
  parameter int unsigned       OP_W     = 6,
  parameter logic [OP_W-1:0]   OP_RTYPE = OP_W'(6'h00),
  parameter logic [OP_W-1:0]   OP_LW    = OP_W'(6'h23),
  parameter logic [OP_W-1:0]   OP_SW    = OP_W'(6'h2B),
  parameter logic [OP_W-1:0]   OP_BEQ   = OP_W'(6'h04),
  parameter logic [OP_W-1:0]   OP_ADDI  = OP_W'(6'h08),
  parameter logic [OP_W-1:0]   OP_J     = OP_W'(6'h02),
  parameter logic [OP_W-1:0]   OP_BNE   = OP_W'(6'h05)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_ne,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            trap,
  output logic            instr_done
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = MEMADR;
        else if (opcode == OP_RTYPE)            state_d = EXEC;
        else if (opcode == OP_BEQ)              state_d = BRANCH;
        else if (opcode == OP_ADDI)             state_d = ADDIEX;
        else if (opcode == OP_J)                state_d = JUMP;
`ifdef MCCTRL_BNE_EN
        else if (opcode == OP_BNE)              state_d = BRANCH;
`else
        else if (opcode == OP_BNE)              state_d = TRAP;
`endif
        else                                    state_d = TRAP;
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

`ifdef MCCTRL_BNE_EN
  // BEQ and BNE share the BRANCH state; the sense is latched at decode.
  logic bne_q, bne_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bne_q <= 1'b0;
    else        bne_q <= bne_d;
  end

  always_comb begin
    bne_d = bne_q;
    if (state_q == DECODE) bne_d = (opcode == OP_BNE);
  end

  assign branch_ne = bne_q && (state_q == BRANCH);
`else
  assign branch_ne = 1'b0;
`endif

  mcctrl_out_decode u_out (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_src        = ctrl.pc_src;
  assign trap          = ctrl.trap;
  assign instr_done    = ctrl.instr_done;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM (plus memory-ready qualification) that sequences fetch/decode/execute over several cycles for a shared-memory, shared-ALU datapath.
- Opcode width and encodings are parametrised; adds ADDI, J, memory wait states and an illegal-opcode trap.
- Sits between the instruction register opcode field and the multicycle datapath muxes, register enables and memory.

Parameters:
- OP_W, 6, opcode field width.
- OP_RTYPE, 6'h00, R-format opcode.
- OP_LW, 6'h23, load word.
- OP_SW, 6'h2B, store word.
- OP_BEQ, 6'h04, branch if equal.
- OP_ADDI, 6'h08, add immediate.
- OP_J, 6'h02, jump.
- OP_BNE, 6'h05, branch if not equal (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OP_W  instruction opcode from the IR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- branch_ne  out  1  branch sense: 0 = take on zero, 1 = take on nonzero.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate << 2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- trap  out  1  illegal opcode seen; sticky.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset: state = IDLE while rst_n = 0, asynchronously. In IDLE all outputs are 0, trap included.
- Unlisted outputs are 0 in every state.
- IDLE -> FETCH unconditionally.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write = mem_ready and pc_write = mem_ready.
  - Holds while mem_ready = 0; -> DECODE when mem_ready = 1.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode: LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP; any other -> TRAP.
- MEMADR:
  - alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - -> MEMRD if LW, else MEMWR.
- MEMRD:
  - mem_read = 1, iord = 1.
  - Holds until mem_ready; then -> MEMWB.
- MEMWB:
  - reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1.
  - -> FETCH.
- MEMWR:
  - mem_write = 1, iord = 1.
  - Holds until mem_ready; instr_done = mem_ready; then -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; -> ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1; -> FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_src = 01, branch_ne = 0.
  - instr_done = 1; -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00; -> ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1; -> FETCH.
- JUMP: pc_write = 1, pc_src = 10, instr_done = 1; -> FETCH.
- TRAP:
  - trap = 1; all other outputs 0.
  - Terminal until reset; opcode and mem_ready are ignored.
- Latencies, with mem_ready = 1 every cycle:
  - LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ and J 3 cycles.
  - Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- Opcode is sampled only in DECODE, and in MEMADR for the LW/SW choice.
- Opcode changes in any other state have no effect.
- Reset asserted mid-instruction: immediate return to IDLE and all outputs 0 in the same cycle. No partial writes are issued after reset deasserts.
- mem_write and reg_write are never asserted in the same cycle.
- pc_write and pc_write_cond are never both 1.

Optional Feature:
- MCCTRL_BNE_EN defined:
  - OP_BNE in DECODE -> BRANCH.
  - Outputs as for BEQ, except branch_ne = 1.
- MCCTRL_BNE_EN undefined:
  - OP_BNE is an illegal opcode -> TRAP.
  - branch_ne is tied 0.

Decomposition:
- Package mcctrl_pkg holds:
  - The state enum: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
  - Localparams for the alu_op, alu_src_b and pc_src codes.
- One sub-module, mcctrl_out_decode: purely combinational map from state plus mem_ready to all control outputs.
- The top level keeps the state register and the next-state logic.

Test Plan:
- Reset, then opcode = 6'h23 with mem_ready = 1 -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write = 1 with mem_to_reg = 1 in cycle 6; instr_done pulses once.
- SW with mem_ready held 0 for 3 cycles in MEMWR -> mem_write = 1 for 4 cycles; instr_done only on the mem_ready cycle; reg_write never 1.
- R-type, then BEQ, then J back-to-back -> alu_op = 10 in EXEC; pc_write_cond = 1 with pc_src = 01 in BRANCH; pc_write = 1 with pc_src = 10 in JUMP; 4 + 3 + 3 cycles.
- Opcode 6'h3F in DECODE -> TRAP next cycle; trap stays 1 under any opcode and mem_ready; rst_n low clears it asynchronously.
- rst_n pulsed low during MEMRD -> all outputs 0 before the next edge; after release, IDLE then FETCH with no reg_write.
- OP_BNE (6'h05): with MCCTRL_BNE_EN -> BRANCH with branch_ne = 1; without it -> TRAP.
